// File: rtl/smtoc2_serial.sv
// Bit-serial sign-magnitude to two's-complement converter. One word per start,
// magnitude walked LSB-first, negatives negated with the copy-to-first-one rule.
module smtoc2_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] sm_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] c2_out,
  output logic             neg_zero
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sign;
  logic             r_seen;
  logic [WIDTH-2:0] r_mag;
  logic [WIDTH-2:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_c2;
  logic             r_negz;

  logic             w_bit;
  logic             w_out_bit;
  logic             w_seen_nxt;
  logic [WIDTH-1:0] w_res_ext;
  logic [WIDTH-2:0] w_res_nxt;
  logic             w_last;

  // Serial negate: once a 1 has passed, every later magnitude bit is inverted.
  assign w_bit      = r_mag[0];
  assign w_out_bit  = (r_sign & r_seen) ? ~w_bit : w_bit;
  assign w_seen_nxt = r_seen | w_bit;
  assign w_res_ext  = {w_out_bit, r_res};
  assign w_res_nxt  = w_res_ext[WIDTH-1:1];
  assign w_last     = (r_cnt == LAST_BIT);

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sign  <= 1'b0;
      r_seen  <= 1'b0;
      r_mag   <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_c2    <= '0;
      r_negz  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sign <= sm_in[WIDTH-1];
            r_mag  <= sm_in[WIDTH-2:0];
            r_seen <= 1'b0;
            r_res  <= '0;
            r_cnt  <= '0;
          end
        end
        S_SHIFT: begin
          r_mag  <= r_mag >> 1;
          r_res  <= w_res_nxt;
          r_seen <= w_seen_nxt;
          r_cnt  <= r_cnt + 1'b1;
          // Sign bit of the result is 1 only for a nonzero negative magnitude.
          if (w_last) begin
            r_c2   <= {r_sign & w_seen_nxt, w_res_nxt};
            r_negz <= r_sign & ~w_seen_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign c2_out   = r_c2;
  assign neg_zero = r_negz;

endmodule
